// File: rtl/counter_reg_x.sv
// rtl/counter_reg_x.sv - bounded up/down counter-register with wrap/saturate/auto-reload overflow modes
module counter_reg_x #(
   parameter int WIDTH         = 16,
   parameter int MIN_VALUE     = 0,
   parameter int MAX_VALUE     = 2**WIDTH-1,
   parameter int DEFAULT_VALUE = 0,
   parameter int STEP          = 1,
   parameter int MODE          = 0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CL,
   input  logic             LD,
   input  logic             INC,
   input  logic             DEC,
   input  logic             RLD_WE,
   input  logic [WIDTH-1:0] DATA_IN,
   output logic [WIDTH-1:0] DATA_OUT,
   output logic             AT_MIN,
   output logic             AT_MAX,
   output logic             TC
);

   localparam int W1 = WIDTH + 1;

   localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VALUE);
   localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0] DEF_W  = WIDTH'(DEFAULT_VALUE);
   localparam logic [WIDTH:0]   MIN_X  = W1'(MIN_VALUE);
   localparam logic [WIDTH:0]   MAX_X  = W1'(MAX_VALUE);
   localparam logic [WIDTH:0]   STEP_X = W1'(STEP);
   localparam logic [WIDTH:0]   RNG_X  = W1'(MAX_VALUE - MIN_VALUE + 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rld_q, rld_d;
   logic             tc_q, tc_d;
   logic [WIDTH:0]   sum_x, dif_x;

   function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] x);
      if (x < MIN_W)
         return MIN_W;
      else if (x > MAX_W)
         return MAX_W;
      else
         return x;
   endfunction

   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      rld_d = RLD_WE ? clamp(DATA_IN) : rld_q;
      sum_x = {1'b0, cnt_q} + STEP_X;
      dif_x = {1'b0, cnt_q} - STEP_X;

      if (CL) begin
         cnt_d = MIN_W;
      end else if (LD) begin
         cnt_d = clamp(DATA_IN);
      end else if (INC && !DEC) begin
         if (sum_x <= MAX_X) begin
            cnt_d = WIDTH'(sum_x);
         end else begin
            tc_d = 1'b1;
            case (MODE)
               0:       cnt_d = WIDTH'(sum_x - RNG_X);
               1:       cnt_d = MAX_W;
               default: cnt_d = MIN_W;
            endcase
         end
      end else if (DEC && !INC) begin
         // Signed compare: dif_x goes negative when STEP exceeds the count.
         if ($signed(dif_x) >= $signed(MIN_X)) begin
            cnt_d = WIDTH'(dif_x);
         end else begin
            tc_d = 1'b1;
            case (MODE)
               0:       cnt_d = WIDTH'(dif_x + RNG_X);
               1:       cnt_d = MIN_W;
               default: cnt_d = rld_q;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt_q <= DEF_W;
         rld_q <= MAX_W;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rld_q <= rld_d;
         tc_q  <= tc_d;
      end
   end

   assign DATA_OUT = cnt_q;
   assign AT_MIN   = (cnt_q == MIN_W);
   assign AT_MAX   = (cnt_q == MAX_W);
   assign TC       = tc_q;

endmodule

// File: tb/tb_counter_reg_x.sv
// tb/tb_counter_reg_x.sv - directed self-checking bench for counter_reg_x
module tb_counter_reg_x;

   logic       clk;
   logic       rst_n;
   logic       cl, ld, inc, dec, rld_we;
   logic [7:0] din;

   logic [7:0] w_q, s_q, r_q, c_q;
   logic       w_min, w_max, w_tc;
   logic       s_min, s_max, s_tc;
   logic       r_min, r_max, r_tc;
   logic       c_min, c_max, c_tc;

   int errors = 0;
   int checks = 0;

   counter_reg_x #(.WIDTH(8), .MIN_VALUE(2), .MAX_VALUE(10), .DEFAULT_VALUE(4), .STEP(3), .MODE(0)) u_wrap (
      .CLK(clk), .RST_N(rst_n), .CL(cl), .LD(ld), .INC(inc), .DEC(dec), .RLD_WE(rld_we),
      .DATA_IN(din), .DATA_OUT(w_q), .AT_MIN(w_min), .AT_MAX(w_max), .TC(w_tc));

   counter_reg_x #(.WIDTH(8), .MIN_VALUE(2), .MAX_VALUE(10), .DEFAULT_VALUE(4), .STEP(3), .MODE(1)) u_sat (
      .CLK(clk), .RST_N(rst_n), .CL(cl), .LD(ld), .INC(inc), .DEC(dec), .RLD_WE(rld_we),
      .DATA_IN(din), .DATA_OUT(s_q), .AT_MIN(s_min), .AT_MAX(s_max), .TC(s_tc));

   counter_reg_x #(.WIDTH(8), .MIN_VALUE(0), .MAX_VALUE(10), .DEFAULT_VALUE(4), .STEP(1), .MODE(2)) u_rld (
      .CLK(clk), .RST_N(rst_n), .CL(cl), .LD(ld), .INC(inc), .DEC(dec), .RLD_WE(rld_we),
      .DATA_IN(din), .DATA_OUT(r_q), .AT_MIN(r_min), .AT_MAX(r_max), .TC(r_tc));

   counter_reg_x #(.WIDTH(8), .MIN_VALUE(2), .MAX_VALUE(10), .DEFAULT_VALUE(4), .STEP(3), .MODE(2)) u_clmp (
      .CLK(clk), .RST_N(rst_n), .CL(cl), .LD(ld), .INC(inc), .DEC(dec), .RLD_WE(rld_we),
      .DATA_IN(din), .DATA_OUT(c_q), .AT_MIN(c_min), .AT_MAX(c_max), .TC(c_tc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cl = 0; ld = 0; inc = 0; dec = 0; rld_we = 0;
   endtask

   int rseq1 [8] = '{0, 5, 4, 3, 2, 1, 0, 5};
   int rtc1  [8] = '{0, 1, 0, 0, 0, 0, 0, 1};
   int rseq2 [6] = '{4, 3, 2, 1, 0, 8};
   int rtc2  [6] = '{0, 0, 0, 0, 0, 1};

   initial begin
      idle();
      din   = 8'd0;
      rst_n = 1'b0;
      inc   = 1;
      tick(); tick();
      chk("rst_q",    w_q,   4);
      chk("rst_tc",   w_tc,  0);
      chk("rst_min",  w_min, 0);
      chk("rst_max",  w_max, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_inc1", w_q, 7);
      tick();
      chk("rst_inc2", w_q, 10);
      chk("rst_atmax", w_max, 1);

      // wrap
      idle(); ld = 1; din = 8'd9; tick();
      chk("wrap_ld", w_q, 9);
      idle(); inc = 1; tick();
      chk("wrap_up_q", w_q, 3);
      chk("wrap_up_tc", w_tc, 1);
      idle(); dec = 1; tick();
      chk("wrap_dn_q", w_q, 9);
      chk("wrap_dn_tc", w_tc, 1);
      tick();
      chk("wrap_dn2_q", w_q, 6);
      chk("wrap_dn2_tc", w_tc, 0);

      // saturate
      idle(); ld = 1; din = 8'd9; tick();
      idle(); inc = 1; tick();
      chk("sat_up_q", s_q, 10);
      chk("sat_up_tc", s_tc, 1);
      tick();
      chk("sat_up2_q", s_q, 10);
      chk("sat_up2_tc", s_tc, 1);
      idle(); ld = 1; din = 8'd4; tick();
      chk("sat_ld_tc", s_tc, 0);
      idle(); dec = 1; tick();
      chk("sat_dn_q", s_q, 2);
      chk("sat_dn_tc", s_tc, 1);
      chk("sat_dn_min", s_min, 1);
      idle(); tick();
      chk("sat_idle_tc", s_tc, 0);

      // auto-reload timer, with a reload write on the second underflow edge
      idle(); rld_we = 1; din = 8'd5; tick();
      idle(); ld = 1; din = 8'd1; tick();
      chk("rld_ld", r_q, 1);
      idle(); dec = 1;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin rld_we = 1; din = 8'd8; end
         tick();
         rld_we = 0;
         chk($sformatf("rld_a%0d_q", i), r_q, rseq1[i]);
         chk($sformatf("rld_a%0d_tc", i), r_tc, rtc1[i]);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("rld_b%0d_q", i), r_q, rseq2[i]);
         chk($sformatf("rld_b%0d_tc", i), r_tc, rtc2[i]);
      end

      // priority and hold
      idle(); cl = 1; ld = 1; inc = 1; din = 8'd7; tick();
      chk("pri_cl_q", w_q, 2);
      chk("pri_cl_min", w_min, 1);
      idle(); ld = 1; inc = 1; din = 8'd7; tick();
      chk("pri_ld_q", w_q, 7);
      idle(); inc = 1; dec = 1; tick();
      chk("pri_hold_q", w_q, 7);
      chk("pri_hold_tc", w_tc, 0);

      // clamping
      idle(); ld = 1; din = 8'd0; tick();
      chk("clamp_lo", w_q, 2);
      idle(); ld = 1; din = 8'd200; tick();
      chk("clamp_hi", w_q, 10);
      chk("clamp_hi_max", w_max, 1);
      idle(); rld_we = 1; din = 8'd1; tick();
      idle(); ld = 1; din = 8'd3; tick();
      idle(); dec = 1; tick();
      chk("rclamp_lo_q", c_q, 2);
      chk("rclamp_lo_tc", c_tc, 1);
      idle(); rld_we = 1; din = 8'd200; tick();
      idle(); ld = 1; din = 8'd3; tick();
      idle(); dec = 1; tick();
      chk("rclamp_hi_q", c_q, 10);

      // reset mid-count
      idle(); inc = 1; rst_n = 1'b0; tick();
      chk("midrst_q", w_q, 4);
      chk("midrst_tc", w_tc, 0);
      rst_n = 1'b1; idle(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
